// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard receiver.
//   ps2_state_t   : frame FSM states
//   PS2_EXT       : extended-key prefix byte
//   PS2_BRK       : break (key release) prefix byte
//   PS2_DATA_BITS : data bits per frame
//   odd_parity_ok : true when data byte plus parity bit has odd weight
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_t;

  localparam logic [7:0] PS2_EXT       = 8'hE0;
  localparam logic [7:0] PS2_BRK       = 8'hF0;
  localparam int         PS2_DATA_BITS = 8;

  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_filter.sv
// Input conditioner for one raw PS/2 pin.
// A 2-FF synchroniser runs on every clock; the filtered level only follows
// the synchronised level after FILTER consecutive ce samples that disagree
// with the current filtered level.
// Ports:
//   clock, reset : system clock, asynchronous active-high reset
//   ce           : sampling enable for the stability counter
//   in           : raw asynchronous pin (idle high)
//   out          : filtered level (resets high)
//   fall         : one-clock pulse on the ce tick where out goes 1->0
module ps2_filter
  import ps2_pkg::*;
#(
  parameter int FILTER = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic ce,
  input  logic in,
  output logic out,
  output logic fall
);

  localparam int CW = $clog2(FILTER + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic          sync_p0;
  logic          sync_p1;
  logic [CW-1:0] cnt;
  logic          settle;

  // stage p0/p1: metastability synchroniser, free-running on every clock
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
    end else begin
      sync_p0 <= in;
      sync_p1 <= sync_p0;
    end
  end

  // the tick on which the new level has been seen FILTER times in a row
  assign settle = ce && (sync_p1 != out) && (cnt == CNT_LAST);
  assign fall   = settle && out;

  // stage p2: stability counter and filtered level
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out <= 1'b1;
      cnt <= '0;
    end else if (ce) begin
      if (sync_p1 == out) begin
        cnt <= '0;
      end else if (settle) begin
        out <= sync_p1;
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 host-side keyboard receiver.
// Deserialises 11-bit device-clocked frames, folds the E0 (extended) and
// F0 (break) prefixes into flags, and emits one key event per scancode.
// Ports:
//   clock, reset : system clock, asynchronous active-high reset
//   ce           : sampling enable; everything except synchronisers waits on it
//   ps2Ck, ps2D  : raw PS/2 clock and data pins (inputs only, never driven)
//   strobe       : one-clock pulse marking a key event
//   press        : 1 = make, 0 = break; held until the next strobe
//   code         : scancode without prefixes; held until the next strobe
//   extended     : event carried an E0 prefix; held until the next strobe
//   error        : one-clock pulse on parity/stop error or frame timeout
module ps2_keyboard_rx
  import ps2_pkg::*;
#(
  parameter int FILTER  = 8,
  parameter int TIMEOUT = 14000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ce,
  input  logic       ps2Ck,
  input  logic       ps2D,
  output logic       strobe,
  output logic       press,
  output logic [7:0] code,
  output logic       extended,
  output logic       error
);

  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TIMER_ONE  = TW'(1);
  localparam logic [2:0]    BIT_LAST   = 3'(PS2_DATA_BITS - 1);

  ps2_state_t    state;
  ps2_state_t    state_nxt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_bit;
  logic [TW-1:0] timer;
  logic          ext_flag;
  logic          brk_flag;

  logic          sample;
  logic          d_level;
  logic          ck_level_unused;
  logic          d_fall_unused;
  logic          tmo;
  logic          frame_ok;

  // stage p0..p2: synchronise and deglitch both pins with equal delay
  ps2_filter #(.FILTER(FILTER)) u_ck_filter (
    .clock (clock),
    .reset (reset),
    .ce    (ce),
    .in    (ps2Ck),
    .out   (ck_level_unused),
    .fall  (sample)
  );

  ps2_filter #(.FILTER(FILTER)) u_d_filter (
    .clock (clock),
    .reset (reset),
    .ce    (ce),
    .in    (ps2D),
    .out   (d_level),
    .fall  (d_fall_unused)
  );

  // a bit-sample event on the expiry tick wins over the timeout
  assign tmo      = ce && !sample && (state != IDLE) && (timer == TIMER_LAST);
  assign frame_ok = d_level && odd_parity_ok(shreg, par_bit);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (tmo) begin
      state_nxt = IDLE;
    end else if (sample) begin
      unique case (state)
        IDLE:    if (!d_level) state_nxt = DATA;
        DATA:    if (bit_cnt == BIT_LAST) state_nxt = PARITY;
        PARITY:  state_nxt = STOP;
        STOP:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // stage p3: frame assembly, prefix flags and registered event outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bit_cnt  <= '0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      timer    <= '0;
      ext_flag <= 1'b0;
      brk_flag <= 1'b0;
      strobe   <= 1'b0;
      press    <= 1'b0;
      code     <= '0;
      extended <= 1'b0;
      error    <= 1'b0;
    end else begin
      strobe <= 1'b0;
      error  <= 1'b0;

      if (ce) begin
        if (sample || tmo || (state == IDLE)) begin
          timer <= '0;
        end else begin
          timer <= timer + TIMER_ONE;
        end
      end

      if (tmo) begin
        ext_flag <= 1'b0;
        brk_flag <= 1'b0;
        error    <= 1'b1;
      end else if (sample) begin
        unique case (state)
          IDLE: bit_cnt <= '0;
          DATA: begin
            shreg   <= {d_level, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
          end
          PARITY: par_bit <= d_level;
          STOP: begin
            if (!frame_ok) begin
              error    <= 1'b1;
              ext_flag <= 1'b0;
              brk_flag <= 1'b0;
            end else if (shreg == PS2_EXT) begin
              ext_flag <= 1'b1;
            end else if (shreg == PS2_BRK) begin
              brk_flag <= 1'b1;
            end else begin
              strobe   <= 1'b1;
              code     <= shreg;
              press    <= !brk_flag;
              extended <= ext_flag;
              ext_flag <= 1'b0;
              brk_flag <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Testbench for ps2_keyboard_rx: table of directed frames plus hand-written
// sequences for timeout, ce hold, clock glitch and mid-frame reset.
module tb_ps2_keyboard_rx;

  localparam int FILT = 8;
  localparam int TMO  = 300;
  localparam int H    = 24;   // half PS/2 clock period, in system clocks

  logic       clock = 1'b0;
  logic       reset;
  logic       ce;
  logic       ps2Ck;
  logic       ps2D;
  logic       strobe;
  logic       press;
  logic [7:0] code;
  logic       extended;
  logic       error;

  int ce_mode = 0;   // 0: ce every clock, 1: every other clock, 2: held low
  int n_strobe = 0;
  int n_error = 0;
  int checks = 0;
  int failures = 0;

  ps2_keyboard_rx #(.FILTER(FILT), .TIMEOUT(TMO)) dut (
    .clock    (clock),
    .reset    (reset),
    .ce       (ce),
    .ps2Ck    (ps2Ck),
    .ps2D     (ps2D),
    .strobe   (strobe),
    .press    (press),
    .code     (code),
    .extended (extended),
    .error    (error)
  );

  always #5 clock = ~clock;

  initial begin
    ce = 1'b1;
    forever begin
      @(negedge clock);
      if (ce_mode == 0)      ce = 1'b1;
      else if (ce_mode == 1) ce = ~ce;
      else                   ce = 1'b0;
    end
  end

  // counts clocks with each pulse high, so a stretched pulse counts twice
  always @(negedge clock) begin
    if (strobe === 1'b1) n_strobe++;
    if (error === 1'b1)  n_error++;
  end

  typedef struct {
    logic [7:0] b;
    bit         par_flip;
    bit         stop;
    bit         ce_half;
    int         exp_strobe;
    int         exp_error;
    logic [7:0] exp_code;
    bit         exp_press;
    bit         exp_ext;
  } vec_t;

  vec_t vecs[14];

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  task automatic send_bit(input bit b);
    ps2D = b;
    wait_clk(H / 2);
    ps2Ck = 1'b0;
    wait_clk(H);
    ps2Ck = 1'b1;
    wait_clk(H / 2);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit par_flip, input bit stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit((~^b) ^ par_flip);
    send_bit(stop);
    ps2D = 1'b1;
  endtask

  task automatic chk_event(input string nm, input int s0, input int e0,
                           input int es, input int ee, input logic [7:0] ec,
                           input bit ep, input bit ex);
    chk({nm, "_strobes"}, n_strobe - s0, es);
    chk({nm, "_errors"}, n_error - e0, ee);
    chk({nm, "_code"}, int'(code), int'(ec));
    chk({nm, "_press"}, int'(press), int'(ep));
    chk({nm, "_ext"}, int'(extended), int'(ex));
  endtask

  initial begin
    int s0;
    int e0;
    logic [7:0] byte_v;

    //            byte   pf stp ceh  s  e  code   p  x
    vecs[0]  = '{8'h1C, 0, 1, 0,   1, 0, 8'h1C, 1, 0};
    vecs[1]  = '{8'hF0, 0, 1, 0,   0, 0, 8'h1C, 1, 0};
    vecs[2]  = '{8'h1C, 0, 1, 0,   1, 0, 8'h1C, 0, 0};
    vecs[3]  = '{8'hE0, 0, 1, 0,   0, 0, 8'h1C, 0, 0};
    vecs[4]  = '{8'hF0, 0, 1, 0,   0, 0, 8'h1C, 0, 0};
    vecs[5]  = '{8'h75, 0, 1, 0,   1, 0, 8'h75, 0, 1};
    vecs[6]  = '{8'h29, 0, 1, 0,   1, 0, 8'h29, 1, 0};
    vecs[7]  = '{8'hF0, 0, 1, 0,   0, 0, 8'h29, 1, 0};
    vecs[8]  = '{8'h1C, 1, 1, 0,   0, 1, 8'h29, 1, 0};
    vecs[9]  = '{8'h1C, 0, 1, 0,   1, 0, 8'h1C, 1, 0};
    vecs[10] = '{8'hE0, 0, 0, 0,   0, 1, 8'h1C, 1, 0};
    vecs[11] = '{8'hE1, 0, 1, 0,   1, 0, 8'hE1, 1, 0};
    vecs[12] = '{8'hE0, 0, 1, 1,   0, 0, 8'hE1, 1, 0};
    vecs[13] = '{8'h6B, 0, 1, 1,   1, 0, 8'h6B, 1, 1};

    reset = 1'b1;
    ps2Ck = 1'b1;
    ps2D  = 1'b1;
    wait_clk(5);
    chk("rst_strobe", int'(strobe), 0);
    chk("rst_press", int'(press), 0);
    chk("rst_code", int'(code), 0);
    chk("rst_ext", int'(extended), 0);
    chk("rst_error", int'(error), 0);
    reset = 1'b0;
    wait_clk(40);

    for (int i = 0; i < 14; i++) begin
      ce_mode = vecs[i].ce_half ? 1 : 0;
      s0 = n_strobe;
      e0 = n_error;
      send_frame(vecs[i].b, vecs[i].par_flip, vecs[i].stop);
      wait_clk(20);
      ce_mode = 0;
      wait_clk(4);
      chk_event($sformatf("row%0d", i), s0, e0, vecs[i].exp_strobe, vecs[i].exp_error,
                vecs[i].exp_code, vecs[i].exp_press, vecs[i].exp_ext);
    end

    // frame abandoned after four data bits, then a full frame recovers
    s0 = n_strobe;
    e0 = n_error;
    byte_v = 8'h1C;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(byte_v[i]);
    wait_clk(TMO - 50);
    chk("tmo_early_errors", n_error - e0, 0);
    wait_clk(150);
    chk("tmo_errors", n_error - e0, 1);
    chk("tmo_strobes", n_strobe - s0, 0);
    s0 = n_strobe;
    e0 = n_error;
    send_frame(8'h1C, 1'b0, 1'b1);
    wait_clk(20);
    chk_event("tmo_recover", s0, e0, 1, 0, 8'h1C, 1, 0);

    // ce held low mid-frame well past the timeout: nothing may advance
    s0 = n_strobe;
    e0 = n_error;
    byte_v = 8'h5A;
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(byte_v[i]);
    ce_mode = 2;
    wait_clk(TMO + 200);
    ce_mode = 0;
    for (int i = 3; i < 8; i++) send_bit(byte_v[i]);
    send_bit(~^byte_v);
    send_bit(1'b1);
    wait_clk(20);
    chk_event("ce_hold", s0, e0, 1, 0, 8'h5A, 1, 0);

    // 3-tick low glitch on ps2Ck with data low must not start a frame
    s0 = n_strobe;
    e0 = n_error;
    ps2D = 1'b0;
    wait_clk(4);
    ps2Ck = 1'b0;
    wait_clk(3);
    ps2Ck = 1'b1;
    wait_clk(40);
    ps2D = 1'b1;
    wait_clk(40);
    chk("glitch_strobes", n_strobe - s0, 0);
    chk("glitch_errors", n_error - e0, 0);
    send_frame(8'h33, 1'b0, 1'b1);
    wait_clk(20);
    chk_event("glitch_after", s0, e0, 1, 0, 8'h33, 1, 0);

    // reset after bit 5 of a frame, then a stray 1 and a clean frame
    s0 = n_strobe;
    byte_v = 8'h1C;
    send_bit(1'b0);
    for (int i = 0; i < 5; i++) send_bit(byte_v[i]);
    reset = 1'b1;
    wait_clk(3);
    chk("midrst_strobe", int'(strobe), 0);
    chk("midrst_code", int'(code), 0);
    chk("midrst_press", int'(press), 0);
    chk("midrst_ext", int'(extended), 0);
    chk("midrst_error", int'(error), 0);
    reset = 1'b0;
    wait_clk(20);
    chk("midrst_strobes", n_strobe - s0, 0);
    s0 = n_strobe;
    e0 = n_error;
    send_bit(1'b1);
    send_frame(8'h5A, 1'b0, 1'b1);
    wait_clk(20);
    chk_event("midrst_after", s0, e0, 1, 0, 8'h5A, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
